// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and helpers for the keypad scanner.
//   KEY_NONE      - committed code meaning "no key / invalid"
//   ROWS, COLS    - matrix geometry
//   row_state_t   - row FSM state encoding (also exposed for debug)
//   ROW_DRIVE*    - active-low row drive pattern for each state
//   key_to_onehot - maps key index r*4+c to its one-hot code
//   row_drive     - maps a row state to its drive pattern
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam logic [15:0] KEY_NONE = 16'h0000;

  typedef enum logic [1:0] {
    DRIVE0 = 2'd0,
    DRIVE1 = 2'd1,
    DRIVE2 = 2'd2,
    DRIVE3 = 2'd3
  } row_state_t;

  localparam logic [3:0] ROW_DRIVE0 = 4'b1110;
  localparam logic [3:0] ROW_DRIVE1 = 4'b1101;
  localparam logic [3:0] ROW_DRIVE2 = 4'b1011;
  localparam logic [3:0] ROW_DRIVE3 = 4'b0111;

  function automatic logic [15:0] key_to_onehot(input logic [3:0] idx);
    logic [15:0] v;
    v = 16'h0001 << idx;
    return v;
  endfunction

  function automatic logic [3:0] row_drive(input row_state_t s);
    logic [3:0] v;
    case (s)
      DRIVE0:  v = ROW_DRIVE0;
      DRIVE1:  v = ROW_DRIVE1;
      DRIVE2:  v = ROW_DRIVE2;
      default: v = ROW_DRIVE3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/keypad_scanner_frame_debounce.sv
// frame_debounce: debounces full-matrix frame codes and commits a key code.
//   clk, rst    - clock, synchronous active-high reset
//   frame_end   - one-cycle pulse, frame_code is valid in this cycle
//   frame_code  - one-hot code of the frame just completed (0 = none/invalid)
//   onehot      - committed key code, constant between commits
//   key_press   - one-cycle strobe coincident with a new nonzero onehot
module frame_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_end,
  input  logic [15:0] frame_code,
  output logic [15:0] onehot,
  output logic        key_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [15:0]      cand;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment; once saturated every further matching frame
  // re-evaluates the commit condition.
  always_comb begin
    cnt_inc = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= KEY_NONE;
      stable_cnt <= '0;
      onehot     <= KEY_NONE;
      key_press  <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (frame_end) begin
        if (frame_code == cand) begin
          stable_cnt <= cnt_inc;
          if (cnt_inc == CNT_MAX && cand != onehot) begin
            onehot    <= cand;
            // Releases (commit of KEY_NONE) are silent.
            key_press <= (cand != KEY_NONE);
          end
        end else begin
          cand       <= frame_code;
          stable_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad front end.
//   clk, rst   - clock, synchronous active-high reset
//   row        - registered active-low row drive, exactly one bit low
//   col        - asynchronous active-low column sense
//   onehot     - committed key code onehot[r*4+c], 0 = none or multi-key
//   key_press  - one-cycle strobe when onehot changes to a nonzero value
//   dbg_state  - current row FSM state
// Each row is driven for SCAN_DIV cycles and the synchronised columns are
// sampled on the last cycle of the dwell. Four rows form one frame, whose
// code is handed to frame_debounce on the DRIVE3 sample cycle.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_press,
  output row_state_t  dbg_state
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Column synchroniser; idle (no key) level is all ones.
  logic [3:0] sync1;
  logic [3:0] col_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      col_s <= 4'hF;
    end else begin
      sync1 <= col;
      col_s <= sync1;
    end
  end

  // Row FSM and dwell counter.
  row_state_t       state;
  logic [DIV_W-1:0] div_cnt;
  logic             sample;

  assign sample    = (div_cnt == DIV_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DRIVE0;
      row     <= ROW_DRIVE0;
      div_cnt <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      case (state)
        DRIVE0:  begin state <= DRIVE1; row <= row_drive(DRIVE1); end
        DRIVE1:  begin state <= DRIVE2; row <= row_drive(DRIVE2); end
        DRIVE2:  begin state <= DRIVE3; row <= row_drive(DRIVE3); end
        default: begin state <= DRIVE0; row <= row_drive(DRIVE0); end
      endcase
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Column hit decode for the row being sampled.
  logic [3:0] hits;
  logic [2:0] hit_cnt;
  logic [1:0] hit_col;

  assign hits = ~col_s;

  always_comb begin
    hit_cnt = '0;
    hit_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (hits[c]) begin
        hit_cnt = hit_cnt + 3'd1;
        hit_col = 2'(c);
      end
    end
  end

  // Frame accumulator. The *_n values include the current sample so the
  // DRIVE3 row contributes to the frame code it closes.
  logic       seen, seen_n;
  logic [3:0] key_idx, key_idx_n;
  logic       multi, multi_n;
  logic       frame_end;
  logic [15:0] frame_code;

  always_comb begin
    seen_n    = seen;
    key_idx_n = key_idx;
    multi_n   = multi;
    if (hit_cnt >= 3'd2) begin
      multi_n = 1'b1;
    end else if (hit_cnt == 3'd1) begin
      if (seen) multi_n = 1'b1;
      seen_n    = 1'b1;
      key_idx_n = {state, hit_col};
    end
  end

  assign frame_end  = sample && (state == DRIVE3);
  assign frame_code = (multi_n || !seen_n) ? KEY_NONE : key_to_onehot(key_idx_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      seen    <= 1'b0;
      key_idx <= '0;
      multi   <= 1'b0;
    end else if (sample) begin
      if (frame_end) begin
        seen    <= 1'b0;
        key_idx <= '0;
        multi   <= 1'b0;
      end else begin
        seen    <= seen_n;
        key_idx <= key_idx_n;
        multi   <= multi_n;
      end
    end
  end

  frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .frame_code(frame_code),
    .onehot    (onehot),
    .key_press (key_press)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix model + behavioural reference for keypad_scanner.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]             row;
  logic [3:0]             col;
  logic [15:0]            onehot;
  logic                   key_press;
  keypad_pkg::row_state_t dbg_state;

  logic [15:0] closed = 16'h0000;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .onehot   (onehot),
    .key_press(key_press),
    .dbg_state(dbg_state)
  );

  // Matrix: col[c] pulled low while row[r] is low and key (r,c) is closed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && closed[r*4+c]) col[c] = 1'b0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cyc = clock edges since reset; row r is sampled on the last edge of its
  // dwell using the key matrix as it stood two edges earlier.
  int          m_cyc = 0;
  bit          model_on = 0;
  logic [15:0] ch1 = 16'h0, ch2 = 16'h0;
  int          keys[$];
  logic [15:0] codes[$];
  logic [15:0] exp_onehot = 16'h0;
  logic        exp_press = 1'b0;

  always @(posedge clk) begin
    int          r;
    logic [15:0] code;
    bit          same;
    if (rst) begin
      m_cyc = 0;
      keys.delete();
      codes.delete();
      exp_onehot = 16'h0;
      exp_press  = 1'b0;
      model_on   = 1;
    end else if (model_on) begin
      exp_press = 1'b0;
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
        r = (m_cyc / SCAN_DIV) % 4;
        for (int c = 0; c < 4; c++)
          if (ch2[r*4+c]) keys.push_back(r*4 + c);
        if (r == 3) begin
          code = (keys.size() == 1) ? (16'h0001 << keys[0]) : 16'h0000;
          codes.push_back(code);
          if (codes.size() > DEB) void'(codes.pop_front());
          same = (codes.size() == DEB);
          foreach (codes[i]) if (codes[i] != code) same = 0;
          if (same && code != exp_onehot) begin
            exp_onehot = code;
            exp_press  = (code != 16'h0);
          end
          keys.delete();
        end
      end
      m_cyc++;
    end
    ch2 = ch1;
    ch1 = closed;
  end

  function automatic logic [3:0] exp_row();
    logic [3:0] one;
    one = 4'b0001;
    return 4'hF & ~(one << ((m_cyc / SCAN_DIV) % 4));
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("row", 32'(row), 32'(exp_row()));
      check("state", 32'(dbg_state), 32'((m_cyc / SCAN_DIV) % 4));
      check("onehot", 32'(onehot), 32'(exp_onehot));
      check("key_press", 32'(key_press), 32'(exp_press));
    end
    if (key_press === 1'b1) press_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_onehot(input string name, input logic [15:0] exp, input int budget);
    int i;
    i = 0;
    while (onehot !== exp && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(onehot), 32'(exp));
  endtask

  task automatic check_pulses(input string name, input int p0, input int exp);
    tick(2);
    check(name, 32'(press_cnt - p0), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          p0;
    bit          saw_zero;
    int          i;
    logic [3:0]  exp_rows[5];
    logic [15:0] k;

    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    rst = 1'b1;
    tick(3);
    check("reset_row", 32'(row), 32'h0000_000E);
    check("reset_onehot", 32'(onehot), 32'h0);
    check("reset_press", 32'(key_press), 32'h0);
    rst = 1'b0;

    // Row sequence: one probe in the middle of each 8-cycle dwell.
    p0 = press_cnt;
    tick(4);
    for (int j = 0; j < 5; j++) begin
      check("row_seq", 32'(row), 32'(exp_rows[j]));
      if (j < 4) tick(8);
    end
    check_pulses("idle_no_press", p0, 0);

    // Single press of (2,1), hold, release.
    p0 = press_cnt;
    closed = 16'h0200;
    wait_onehot("press_21", 16'h0200, 131);
    check_pulses("press_21_pulse", p0, 1);
    tick(100);
    check("press_21_hold", 32'(onehot), 32'h0000_0200);
    p0 = press_cnt;
    closed = 16'h0000;
    wait_onehot("release_21", 16'h0000, 131);
    check_pulses("release_21_nopulse", p0, 0);

    // Bounce on (0,3): alternate frames, then hold.
    p0 = press_cnt;
    for (int j = 0; j < 20; j++) begin
      closed[3] = ~closed[3];
      tick(32);
    end
    check("bounce_onehot", 32'(onehot), 32'h0);
    check("bounce_nopulse", 32'(press_cnt - p0), 32'h0);
    closed = 16'h0008;
    wait_onehot("bounce_hold", 16'h0008, 131);
    check_pulses("bounce_hold_pulse", p0, 1);
    closed = 16'h0000;
    wait_onehot("bounce_release", 16'h0000, 131);

    // Multi-key (0,0)+(1,2), then release (1,2).
    p0 = press_cnt;
    closed = 16'h0041;
    tick(160);
    check("multi_onehot", 32'(onehot), 32'h0);
    check("multi_nopulse", 32'(press_cnt - p0), 32'h0);
    closed = 16'h0001;
    wait_onehot("multi_to_single", 16'h0001, 131);
    check_pulses("multi_to_single_pulse", p0, 1);
    closed = 16'h0000;
    wait_onehot("multi_release", 16'h0000, 131);

    // Direct key change (1,3) -> (3,2).
    closed = 16'h0080;
    wait_onehot("change_a", 16'h0080, 131);
    tick(5);
    p0 = press_cnt;
    closed = 16'h4000;
    saw_zero = 0;
    i = 0;
    while (onehot !== 16'h4000 && i < 131) begin
      @(negedge clk);
      if (onehot === 16'h0000) saw_zero = 1;
      i++;
    end
    check("change_b", 32'(onehot), 32'h0000_4000);
    check("change_no_zero", 32'(saw_zero), 32'h0);
    check_pulses("change_pulse", p0, 1);
    closed = 16'h0000;
    wait_onehot("change_release", 16'h0000, 131);

    // Reset while a key is committed and row 2 is being driven.
    closed = 16'h0200;
    wait_onehot("rst_pre", 16'h0200, 131);
    i = 0;
    while ((m_cyc / SCAN_DIV) % 4 != 2 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("rst_in_drive2", 32'((m_cyc / SCAN_DIV) % 4), 32'h2);
    p0 = press_cnt;
    rst = 1'b1;
    tick(1);
    check("rst_mid_row", 32'(row), 32'h0000_000E);
    check("rst_mid_onehot", 32'(onehot), 32'h0);
    rst = 1'b0;
    wait_onehot("rst_recommit", 16'h0200, 131);
    check_pulses("rst_recommit_pulse", p0, 1);
    closed = 16'h0000;
    wait_onehot("rst_release", 16'h0000, 131);

    // Randomised key activity checked by the per-cycle model comparison.
    for (int j = 0; j < 40; j++) begin
      case ($urandom_range(0, 3))
        0: closed = 16'h0000;
        1, 2: begin
          k = 16'h0001;
          closed = k << $urandom_range(0, 15);
        end
        default: begin
          k = 16'h0001;
          closed = (k << $urandom_range(0, 15)) | (k << $urandom_range(0, 15));
        end
      endcase
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(20, 200));
    end
    closed = 16'h0000;
    wait_onehot("final_release", 16'h0000, 131);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
